// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
//   Pipeline sequencer for the 5-stage RISC-V core behind the instruction
//   decoder. Holds the ID/EX, EX/MEM and MEM/WB control shadow registers,
//   resolves data-memory wait freezes, taken-branch flushes and load-use
//   stalls, and produces the EX operand forwarding selects.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   id_valid            IF/ID holds a real instruction
//   id_ctrl[9:0]        {regwrite, alu_control[3:0], alusrc, memread,
//                        memwrite, branch, memtoreg}
//   id_rs1/rs2/rd       register fields of the instruction in ID
//   ex_branch_taken     branch compare result for the instruction in EX
//   mem_ready           data memory completes its access this cycle
//   stall_if, stall_id  hold PC / hold IF/ID
//   flush_id            load a bubble into IF/ID at the next edge
//   ex_*, mem_*, wb_*   registered pipeline control state
//   fwd_a, fwd_b        EX operand selects: 00 regfile, 10 EX/MEM, 01 MEM/WB
//   stall_cnt           saturating count of cycles with stall_if=1
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   id_valid,
  input  logic [9:0]             id_ctrl,
  input  logic [4:0]             id_rs1,
  input  logic [4:0]             id_rs2,
  input  logic [4:0]             id_rd,
  input  logic                   ex_branch_taken,
  input  logic                   mem_ready,
  output logic                   stall_if,
  output logic                   stall_id,
  output logic                   flush_id,
  output logic                   ex_valid,
  output logic [9:0]             ex_ctrl,
  output logic [4:0]             ex_rd,
  output logic                   mem_valid,
  output logic [9:0]             mem_ctrl,
  output logic [4:0]             mem_rd,
  output logic                   wb_valid,
  output logic                   wb_regwrite,
  output logic [4:0]             wb_rd,
  output logic [1:0]             fwd_a,
  output logic [1:0]             fwd_b,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  logic [4:0] r_ex_rs1;
  logic [4:0] r_ex_rs2;

  logic w_freeze;
  logic w_flush;
  logic w_rs2_used;
  logic w_load_use;
  logic w_mem_fwd_ok;
  logic w_wb_fwd_ok;

  // Hazard detection looks only at regwrite, memread, memwrite, branch, alusrc.
  assign w_freeze   = mem_valid & (mem_ctrl[3] | mem_ctrl[2]) & ~mem_ready;
  assign w_flush    = ex_valid & ex_ctrl[1] & ex_branch_taken;
  // Stores read rs2 even though alusrc selects the immediate.
  assign w_rs2_used = ~id_ctrl[4] | id_ctrl[2];
  assign w_load_use = ex_valid & ex_ctrl[3] & (ex_rd != 5'd0) & id_valid &
                      ((id_rs1 == ex_rd) | (w_rs2_used & (id_rs2 == ex_rd)));

  // Freeze dominates; a taken branch suppresses the load-use stall because
  // the dependent ID instruction is on the wrong path anyway.
  assign stall_if = w_freeze | (~w_flush & w_load_use);
  assign stall_id = stall_if;
  assign flush_id = ~w_freeze & w_flush;

  // Loads in MEM have no result yet; their value is taken from WB later.
  assign w_mem_fwd_ok = mem_valid & mem_ctrl[9] & ~mem_ctrl[3] & (mem_rd != 5'd0);
  assign w_wb_fwd_ok  = wb_valid & wb_regwrite & (wb_rd != 5'd0);

  assign fwd_a = (w_mem_fwd_ok && (mem_rd == r_ex_rs1)) ? 2'b10 :
                 (w_wb_fwd_ok  && (wb_rd  == r_ex_rs1)) ? 2'b01 : 2'b00;
  assign fwd_b = (w_mem_fwd_ok && (mem_rd == r_ex_rs2)) ? 2'b10 :
                 (w_wb_fwd_ok  && (wb_rd  == r_ex_rs2)) ? 2'b01 : 2'b00;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid    <= 1'b0;
      ex_ctrl     <= '0;
      ex_rd       <= '0;
      r_ex_rs1    <= '0;
      r_ex_rs2    <= '0;
      mem_valid   <= 1'b0;
      mem_ctrl    <= '0;
      mem_rd      <= '0;
      wb_valid    <= 1'b0;
      wb_regwrite <= 1'b0;
      wb_rd       <= '0;
    end else if (w_freeze) begin
      // EX and MEM hold; the retiring slot becomes a bubble.
      wb_valid    <= 1'b0;
      wb_regwrite <= 1'b0;
      wb_rd       <= '0;
    end else begin
      wb_valid    <= mem_valid;
      wb_regwrite <= mem_ctrl[9];
      wb_rd       <= mem_rd;
      mem_valid   <= ex_valid;
      mem_ctrl    <= ex_ctrl;
      mem_rd      <= ex_rd;
      if (w_flush || w_load_use) begin
        ex_valid <= 1'b0;
        ex_ctrl  <= '0;
        ex_rd    <= '0;
        r_ex_rs1 <= '0;
        r_ex_rs2 <= '0;
      end else begin
        ex_valid <= id_valid;
        ex_ctrl  <= id_ctrl;
        ex_rd    <= id_rd;
        r_ex_rs1 <= id_rs1;
        r_ex_rs2 <= id_rs2;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (stall_if && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + STALL_CNT_W'(1);
    end
  end

endmodule
